conv_cfg_loader: RTL and testbench

Streaming initiator for the convolution block's parameter-memory port. It accepts a byte stream of weights and biases, packs the bytes into words, and issues single-cycle writes across every bank and address of the conv parameter memory. With readback enabled, it reads each word back and compares it. It sits between the host/SPI byte source and the conv layer's `rd_en_i/wr_en_i/rd_wr_bank_i/rd_wr_addr_i/wr_data_i/rd_data_o` port.

---
 rtl/conv_cfg_pkg.sv | 22 ++
 rtl/conv_cfg_packer.sv | 42 ++++
 rtl/conv_cfg_loader.sv | 191 +++++++++++++++++++
 tb/tb_conv_cfg_loader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_cfg_pkg.sv
// Shared constants, FSM encoding and image-size helper for the conv parameter loader.
package conv_cfg_pkg;

    localparam int         FILTER_LEN = 3;
    localparam int         BIAS_BW    = 32;
    localparam logic [1:0] BANK_BIAS  = 2'd3;
    localparam int         NUM_BANKS  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_VERIFY_RD,
        ST_VERIFY_CMP,
        ST_DONE
    } cfg_state_t;

    function automatic int words_per_image(input int num_filters);
        return NUM_BANKS * num_filters;
    endfunction

endpackage

// File: rtl/conv_cfg_packer.sv
// Byte-to-lane packer: first byte lands in lane 0, full after LANES bytes (BIAS_BW/BW for bias words).
// One byte per cycle, no internal backpressure; pushes while full are dropped, clr_i empties it.
module conv_cfg_packer
    import conv_cfg_pkg::*;
#(
    parameter int LANES = 13,
    parameter int BW    = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                push_i,
    input  logic                bias_i,
    input  logic [BW-1:0]       data_i,
    output logic [LANES*BW-1:0] word_o,
    output logic                last_lane_o,
    output logic                full_o
);

    localparam int            CW         = $clog2(LANES + 1);
    localparam logic [CW-1:0] BIAS_LANES = CW'(BIAS_BW / BW);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] n_lanes;

    assign n_lanes     = bias_i ? BIAS_LANES : CW'(LANES);
    assign last_lane_o = (cnt_q == n_lanes - CW'(1));

    // Clearing zeroes the whole word, which is what zero-extends bias words.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            word_o <= '0;
            cnt_q  <= '0;
            full_o <= 1'b0;
        end else if (push_i && !full_o) begin
            word_o[cnt_q*BW +: BW] <= data_i;
            cnt_q                  <= cnt_q + CW'(1);
            full_o                 <= last_lane_o;
        end
    end

endmodule

// File: rtl/conv_cfg_loader.sv
// Packs a config byte stream into conv parameter words and writes them bank-major, one strobe per word.
// Define CONV_CFG_VERIFY_EN to read each word back and compare it; all outputs registered.
module conv_cfg_loader
    import conv_cfg_pkg::*;
#(
    parameter int VECTOR_LEN  = 13,
    parameter int NUM_FILTERS = 8,
    parameter int BW          = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [BW-1:0]                  data_i,
    input  logic                           valid_i,
    input  logic                           last_i,
    output logic                           ready_o,
    output logic                           rd_en_o,
    output logic                           wr_en_o,
    output logic [1:0]                     rd_wr_bank_o,
    output logic [$clog2(NUM_FILTERS)-1:0] rd_wr_addr_o,
    output logic [VECTOR_LEN*BW-1:0]       wr_data_o,
    input  logic [VECTOR_LEN*BW-1:0]       rd_data_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o
);

    localparam int AW        = $clog2(NUM_FILTERS);
    localparam int WW        = VECTOR_LEN * BW;
    localparam int LAST_WORD = words_per_image(NUM_FILTERS) - 1;

    cfg_state_t    state_q;
    cfg_state_t    state_nxt;
    logic [1:0]    bank_q;
    logic [AW-1:0] addr_q;
    logic          last_q;

    logic          acc;
    logic          final_word;
    logic          pk_last_lane;
    logic          pk_full;
    logic          pk_clr;
    logic [WW-1:0] pk_word;
    logic          err_set;
    logic          err_clr;
    logic          cnt_clr;
    logic          adv;

    assign acc          = ready_o && valid_i && !pk_full;
    assign final_word   = (int'(bank_q) * NUM_FILTERS + int'(addr_q)) == LAST_WORD;
    assign rd_wr_bank_o = bank_q;
    assign rd_wr_addr_o = addr_q;
    assign wr_data_o    = pk_word;

    conv_cfg_packer #(
        .LANES (VECTOR_LEN),
        .BW    (BW)
    ) u_packer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (pk_clr),
        .push_i      (acc),
        .bias_i      (bank_q == BANK_BIAS),
        .data_i      (data_i),
        .word_o      (pk_word),
        .last_lane_o (pk_last_lane),
        .full_o      (pk_full)
    );

`ifdef CONV_CFG_VERIFY_EN
    // The packer is emptied in WRITE, so the compare needs its own copy of the word.
    logic [WW-1:0] word_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= '0;
        end else if (state_q == ST_WRITE) begin
            word_q <= pk_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_en_o <= 1'b0;
        end else begin
            rd_en_o <= (state_nxt == ST_VERIFY_RD);
        end
    end
`else
    logic unused_rd_data;
    assign unused_rd_data = ^rd_data_i;
    assign rd_en_o        = 1'b0;
`endif

    always_comb begin
        state_nxt = state_q;
        pk_clr    = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        cnt_clr   = 1'b0;
        adv       = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_nxt = ST_COLLECT;
                    pk_clr    = 1'b1;
                    err_clr   = 1'b1;
                    cnt_clr   = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (acc) begin
                    if (pk_last_lane && final_word) begin
                        state_nxt = ST_WRITE;
                    end else if (last_i) begin
                        // Early end of image: drop the partial word without writing it.
                        state_nxt = ST_DONE;
                        err_set   = 1'b1;
                        pk_clr    = 1'b1;
                    end else if (pk_last_lane) begin
                        state_nxt = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                pk_clr = 1'b1;
`ifdef CONV_CFG_VERIFY_EN
                state_nxt = ST_VERIFY_RD;
`else
                adv       = 1'b1;
                err_set   = final_word && !last_q;
                state_nxt = final_word ? ST_DONE : ST_COLLECT;
`endif
            end
`ifdef CONV_CFG_VERIFY_EN
            ST_VERIFY_RD: begin
                state_nxt = ST_VERIFY_CMP;
            end
            ST_VERIFY_CMP: begin
                adv       = 1'b1;
                err_set   = (rd_data_i != word_q) || (final_word && !last_q);
                state_nxt = final_word ? ST_DONE : ST_COLLECT;
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            bank_q  <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
            ready_o <= 1'b0;
            wr_en_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (acc) begin
                last_q <= last_i;
            end
            if (cnt_clr) begin
                bank_q <= '0;
                addr_q <= '0;
            end else if (adv) begin
                if (addr_q == AW'(NUM_FILTERS - 1)) begin
                    addr_q <= '0;
                    bank_q <= bank_q + 2'd1;
                end else begin
                    addr_q <= addr_q + AW'(1);
                end
            end
            if (err_clr) begin
                err_o <= 1'b0;
            end else if (err_set) begin
                err_o <= 1'b1;
            end
            // Decoded from the next state so every strobe is a flop output.
            ready_o <= (state_nxt == ST_COLLECT);
            wr_en_o <= (state_nxt == ST_WRITE);
            busy_o  <= !(state_nxt inside {ST_IDLE, ST_DONE});
            done_o  <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_conv_cfg_loader.sv
// Directed bench for conv_cfg_loader at default parameters; readback cases build with CONV_CFG_VERIFY_EN.
module tb_conv_cfg_loader;

`ifdef CONV_CFG_VERIFY_EN
    localparam int EXP_CYC = 344 + 32 * 3;
`else
    localparam int EXP_CYC = 344 + 32;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   data;
    logic         valid;
    logic         last;
    logic         ready;
    logic         rd_en;
    logic         wr_en;
    logic [1:0]   bank;
    logic [2:0]   addr;
    logic [103:0] wr_data;
    logic [103:0] rd_data = '0;
    logic         busy;
    logic         done;
    logic         err;

    always #5 clk = ~clk;

    conv_cfg_loader dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .data_i       (data),
        .valid_i      (valid),
        .last_i       (last),
        .ready_o      (ready),
        .rd_en_o      (rd_en),
        .wr_en_o      (wr_en),
        .rd_wr_bank_o (bank),
        .rd_wr_addr_o (addr),
        .wr_data_o    (wr_data),
        .rd_data_i    (rd_data),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    typedef struct packed {
        logic [1:0]   bank;
        logic [2:0]   addr;
        logic [103:0] data;
    } wr_t;

    typedef struct {
        int           idx;
        logic [1:0]   bank;
        logic [2:0]   addr;
        logic [103:0] data;
    } wvec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model; optional single-bit corruption at bank 1 addr 3.
    logic [103:0] mem [4][8];
    bit corrupt = 1'b0;

    always @(posedge clk) begin
        if (wr_en) mem[bank][addr] <= wr_data;
        if (rd_en) rd_data <= mem[bank][addr] ^ ((corrupt && bank == 2'd1 && addr == 3'd3) ? 104'd1 : 104'd0);
    end

    wr_t  wlog[$];
    int   wr_cycles = 0;
    int   rd_cycles = 0;
    int   both_hi = 0;
    int   rd_follow_err = 0;
    int   reads_at_err = 0;
    logic prev_wr = 1'b0;
    logic prev_err = 1'b0;

    always @(negedge clk) begin
        if (wr_en) begin
            wlog.push_back({bank, addr, wr_data});
            wr_cycles++;
        end
        if (rd_en) rd_cycles++;
        if (wr_en && rd_en) both_hi++;
        if (rd_en !== prev_wr) rd_follow_err++;
        if (err && !prev_err) reads_at_err = rd_cycles;
        prev_wr  = wr_en;
        prev_err = err;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [103:0] exp_word(input int k);
        logic [103:0] w;
        int base;
        w = '0;
        if (k < 24) begin
            base = k * 13;
            for (int j = 0; j < 13; j++) w[j*8 +: 8] = 8'((base + j) % 256);
        end else begin
            base = 312 + (k - 24) * 4;
            for (int j = 0; j < 4; j++) w[j*8 +: 8] = 8'((base + j) % 256);
        end
        return w;
    endfunction

    task automatic check_seq(input string name, input int b, input int n);
        int  bad;
        wr_t e;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            e = {2'(k / 8), 3'(k % 8), exp_word(k)};
            if (b + k >= wlog.size()) bad++;
            else if (wlog[b + k] !== e) bad++;
        end
        check({name, "_words_bad"}, 128'(bad), 128'(0));
        check({name, "_write_count"}, 128'(wlog.size() - b), 128'(n));
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_ready"}, 128'(ready), 128'(0));
        check({name, "_wr_en"}, 128'(wr_en), 128'(0));
        check({name, "_rd_en"}, 128'(rd_en), 128'(0));
        check({name, "_bank"}, 128'(bank), 128'(0));
        check({name, "_addr"}, 128'(addr), 128'(0));
        check({name, "_wr_data"}, 128'(wr_data), 128'(0));
        check({name, "_busy"}, 128'(busy), 128'(0));
        check({name, "_done"}, 128'(done), 128'(0));
        check({name, "_err"}, 128'(err), 128'(0));
    endtask

    task automatic do_start(output int s);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s = cyc;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic lst, input int gap, output bit ok);
        int guard;
        guard = 0;
        ok = 1'b0;
        while (gap > 0 && $urandom_range(0, 99) < gap) begin
            valid = 1'b0;
            @(posedge clk); #1;
        end
        valid = 1'b1;
        data  = b;
        last  = lst;
        while (!ok && guard < 50) begin
            ok = ready;
            @(posedge clk); #1;
            guard++;
        end
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic send_image(input string name, input int n, input int last_at, input int gap);
        bit ok;
        int n_acc;
        n_acc = 0;
        for (int i = 0; i < n; i++) begin
            send_byte(8'(i), i == last_at, gap, ok);
            if (!ok) break;
            n_acc++;
        end
        check({name, "_bytes_accepted"}, 128'(n_acc), 128'(n));
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    wvec_t tbl [7];

    initial begin
        int s;
        int b;
        int wb;
        int rb;
        int fb;

        tbl[0] = '{0,  2'd0, 3'd0, 104'h0C0B0A09080706050403020100};
        tbl[1] = '{7,  2'd0, 3'd7, 104'h67666564636261605F5E5D5C5B};
        tbl[2] = '{8,  2'd1, 3'd0, 104'h74737271706F6E6D6C6B6A6968};
        tbl[3] = '{19, 2'd2, 3'd3, 104'h03020100FFFEFDFCFBFAF9F8F7};
        tbl[4] = '{23, 2'd2, 3'd7, 104'h37363534333231302F2E2D2C2B};
        tbl[5] = '{24, 2'd3, 3'd0, 104'h3B3A3938};
        tbl[6] = '{31, 2'd3, 3'd7, 104'h57565554};

        rst = 1'b1; start = 1'b0; valid = 1'b0; data = '0; last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_no_start_ready", 128'(ready), 128'(0));

        // Full image at full rate.
        b = wlog.size(); wb = wr_cycles; rb = rd_cycles; fb = rd_follow_err;
        do_start(s);
        check("start_busy", 128'(busy), 128'(1));
        check("start_ready", 128'(ready), 128'(1));
        send_image("full", 344, 343, 0);
        wait_done(20);
        check("full_load_cycles", 128'(cyc - s), 128'(EXP_CYC));
        check("full_done", 128'(done), 128'(1));
        check("full_err", 128'(err), 128'(0));
        check("full_busy_at_done", 128'(busy), 128'(0));
        check_seq("full", b, 32);
        for (int i = 0; i < 7; i++) begin
            wr_t got;
            got = (b + tbl[i].idx < wlog.size()) ? wlog[b + tbl[i].idx] : '0;
            check($sformatf("tbl_word%0d", tbl[i].idx), 128'(got), 128'({tbl[i].bank, tbl[i].addr, tbl[i].data}));
        end
        check("full_wr_strobe_cycles", 128'(wr_cycles - wb), 128'(32));
        check("strobes_overlap", 128'(both_hi), 128'(0));
`ifdef CONV_CFG_VERIFY_EN
        check("full_rd_strobe_cycles", 128'(rd_cycles - rb), 128'(32));
        check("full_rd_follows_wr", 128'(rd_follow_err - fb), 128'(0));
`else
        check("full_no_reads", 128'(rd_cycles - rb), 128'(0));
`endif

        // Same image with ~50% valid gaps.
        b = wlog.size(); wb = wr_cycles;
        do_start(s);
        send_image("gaps", 344, 343, 50);
        wait_done(20);
        check_seq("gaps", b, 32);
        check("gaps_wr_strobe_cycles", 128'(wr_cycles - wb), 128'(32));
        check("gaps_done", 128'(done), 128'(1));
        check("gaps_err", 128'(err), 128'(0));

        // last_i on byte 100: word 7 incomplete, must be dropped.
        b = wlog.size();
        do_start(s);
        send_image("early", 101, 100, 0);
        check("early_done_next_cycle", 128'(done), 128'(1));
        check("early_err_next_cycle", 128'(err), 128'(1));
        check("early_ready_low", 128'(ready), 128'(0));
        repeat (5) @(posedge clk);
        #1;
        check_seq("early", b, 7);

        // Full image without last_i.
        b = wlog.size();
        do_start(s);
        check("restart_clears_err", 128'(err), 128'(0));
        send_image("nolast", 344, -1, 0);
        wait_done(20);
        check_seq("nolast", b, 32);
        check("nolast_err", 128'(err), 128'(1));
        check("nolast_done", 128'(done), 128'(1));

`ifdef CONV_CFG_VERIFY_EN
        // Corrupted readback at bank 1 addr 3 (word 11).
        corrupt = 1'b1;
        b = wlog.size(); rb = rd_cycles; fb = rd_follow_err;
        do_start(s);
        send_image("verify", 344, 343, 0);
        wait_done(20);
        check_seq("verify", b, 32);
        check("verify_err", 128'(err), 128'(1));
        check("verify_done", 128'(done), 128'(1));
        check("verify_err_after_word11", 128'(reads_at_err - rb), 128'(12));
        check("verify_rd_follows_wr", 128'(rd_follow_err - fb), 128'(0));
        corrupt = 1'b0;
`endif

        // Reset in the middle of a load, then a clean reload.
        do_start(s);
        send_image("midrst", 50, -1, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("midrst");
        rst = 1'b0;
        @(posedge clk); #1;
        b = wlog.size();
        do_start(s);
        send_image("reload", 344, 343, 0);
        wait_done(20);
        check_seq("reload", b, 32);
        check("reload_err", 128'(err), 128'(0));
        check("reload_done", 128'(done), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
